// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
// Self-sequenced multi-cycle datapath. It contains a unified program/data
// memory, a PC, an 8x16 register file, an ALU (ADD/SUB plus LHI/LLI immediate
// loads), flags and an OUT register with a valid/ready handshake. The host
// loads a program while the block is idle or halted, then pulses start. The
// internal FSM fetches and executes instructions until it reaches HLT.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   load_en    : host memory write strobe (honoured only in IDLE/HALT)
//   load_addr  : host memory write address
//   load_data  : host memory write data
//   start      : in IDLE/HALT, restart at RESET_PC; ignored otherwise
//   busy       : high in every state except IDLE and HALT
//   halted     : high in HALT
//   pc         : current program counter
//   out_data   : OUT result; held stable while out_valid is high
//   out_valid  : OUT result available
//   out_ready  : consumer accepts out_data when out_valid & out_ready
//   n_f/z_f/v_f/c_f : ALU flags (negative, zero, overflow, carry)
// ---------------------------------------------------------------------------
module mc_datapath #(
  parameter int                MEM_AW   = 8,
  parameter logic [MEM_AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [MEM_AW-1:0] pc,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              n_f,
  output logic              z_f,
  output logic              v_f,
  output logic              c_f
);

  localparam int MEM_DEPTH = 1 << MEM_AW;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LHI = 4'h2;
  localparam logic [3:0] OP_LLI = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_BZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_OUTW, S_HALT
  } state_t;

  state_t            r_state, w_next;
  logic [MEM_AW-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_regs [8];
  logic [15:0]       r_mem [MEM_DEPTH];
  logic [15:0]       r_mem_q;
  logic [15:0]       r_out_data;
  logic              r_out_valid;
  logic              r_n, r_z, r_v, r_c;

  // Instruction fields
  logic [3:0]        w_op;
  logic [2:0]        w_rd, w_ra, w_rb;
  logic [7:0]        w_imm8;
  logic [MEM_AW-1:0] w_imm;
  logic [15:0]       w_rd_val, w_ra_val, w_rb_val;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:9];
  assign w_ra     = r_ir[8:6];
  assign w_rb     = r_ir[5:3];
  assign w_imm8   = r_ir[7:0];
  assign w_imm    = r_ir[MEM_AW-1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_ra_val = r_regs[w_ra];
  assign w_rb_val = r_regs[w_rb];

  // ALU: SUB is a + ~b + 1, so the carry-out doubles as "no borrow".
  logic        w_is_sub;
  logic [15:0] w_b_opnd;
  logic [16:0] w_sum;
  logic [15:0] w_res;
  logic        w_ovf;

  assign w_is_sub = (w_op == OP_SUB);
  assign w_b_opnd = w_is_sub ? ~w_rb_val : w_rb_val;
  assign w_sum    = {1'b0, w_ra_val} + {1'b0, w_b_opnd} + {16'd0, w_is_sub};
  assign w_res    = w_sum[15:0];
  // Overflow: both effective operands share a sign that the result lacks.
  assign w_ovf    = (w_ra_val[15] == w_b_opnd[15]) && (w_res[15] != w_ra_val[15]);

  logic w_host_ok;
  assign w_host_ok = (r_state == S_IDLE) || (r_state == S_HALT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_LD:   w_next = S_WB;
          OP_OUT:  w_next = S_OUTW;
          OP_HLT:  w_next = S_HALT;
          default: w_next = S_FETCH;
        endcase
      end
      S_WB:           w_next = S_FETCH;
      S_OUTW:         if (out_ready) w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and memory port control ----------------
  logic              w_mem_we;
  logic [MEM_AW-1:0] w_mem_wa;
  logic [15:0]       w_mem_wd;
  logic [MEM_AW-1:0] w_mem_ra;

  always_comb begin
    busy     = !w_host_ok;
    halted   = (r_state == S_HALT);
    w_mem_we = 1'b0;
    w_mem_wa = load_addr;
    w_mem_wd = load_data;
    w_mem_ra = r_pc;
    if (w_host_ok && load_en) begin
      w_mem_we = 1'b1;
    end else if (r_state == S_EXEC && w_op == OP_ST) begin
      w_mem_we = 1'b1;
      w_mem_wa = w_imm;
      w_mem_wd = w_rd_val;
    end
    if (r_state == S_EXEC && w_op == OP_LD) w_mem_ra = w_imm;
  end

  // ---------------- Memory: synchronous read, one cycle latency ----------------
  always_ff @(posedge clk) begin
    // NOTE: the memory array and its read register are deliberately not
    // reset; contents must survive rst and a reset loop would block RAM mapping.
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
    r_mem_q <= r_mem[w_mem_ra];
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      {r_n, r_z, r_v, r_c} <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: if (start) r_pc <= RESET_PC;
        S_DECODE: begin
          r_ir <= r_mem_q;
          r_pc <= r_pc + MEM_AW'(1);
        end
        S_EXEC: begin
          case (w_op)
            OP_ADD, OP_SUB: begin
              r_regs[w_rd] <= w_res;
              r_n <= w_res[15];
              r_z <= (w_res == 16'd0);
              r_v <= w_ovf;
              r_c <= w_sum[16];
            end
            OP_LHI: r_regs[w_rd] <= {w_imm8, w_rd_val[7:0]};
            OP_LLI: r_regs[w_rd] <= {w_rd_val[15:8], w_imm8};
            OP_JMP: r_pc <= w_imm;
            OP_BZ:  if (r_z) r_pc <= w_imm;
            OP_OUT: begin
              r_out_data  <= w_ra_val;
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WB:   r_regs[w_rd] <= r_mem_q;
        S_OUTW: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign pc        = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign n_f       = r_n;
  assign z_f       = r_z;
  assign v_f       = r_v;
  assign c_f       = r_c;

endmodule

// File: tb/tb_mc_datapath.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath
// Directed bench for mc_datapath: loads small programs, runs them, and checks
// OUT beats, flags, pc and cycle counts against hand-computed values.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        busy, halted;
  logic [7:0]  pc;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        n_f, z_f, v_f, c_f;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  logic [15:0] last_beat = '0;
  int cyc;
  int beats0;

  mc_datapath #(.MEM_AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .halted(halted),
    .pc(pc), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .n_f(n_f), .z_f(z_f), .v_f(v_f), .c_f(c_f)
  );

  always #5 clk = ~clk;

  // Handshake monitor: a beat is transferred when valid & ready at an edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      beats     <= beats + 1;
      last_beat <= out_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic wait_halt(inout int c);
    while (halted !== 1'b1 && c < 500) begin
      step();
      c++;
    end
  endtask

  // Pulse start and count edges (start edge included) until halted is seen.
  task automatic run_to_halt(output int c);
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    wait_halt(c);
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("valid_seen", out_valid, 1'b1);
  endtask

  task automatic load_prog1();
    load(8'h00, enc_i(4'h3, 3'd1, 8'h34));   // LLI R1,34
    load(8'h01, enc_i(4'h2, 3'd1, 8'h12));   // LHI R1,12
    load(8'h02, enc_r(4'h8, 3'd0, 3'd1, 3'd0)); // OUT R1
    load(8'h03, 16'hF000);                   // HLT
  endtask

  initial begin
    // ---------------- Reset state ----------------
    step(); step();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_flags", {n_f, z_f, v_f, c_f}, 4'b0000);

    // ---------------- 1: LLI/LHI/OUT/HLT ----------------
    load_prog1();
    beats0 = beats;
    run_to_halt(cyc);
    check("s1_cycles", cyc, 14);
    check("s1_beats", beats - beats0, 1);
    check("s1_data", last_beat, 16'h1234);
    check("s1_pc", pc, 8'h04);
    check("s1_busy", busy, 1'b0);
    check("s1_valid_low", out_valid, 1'b0);

    // ---------------- 2: ADD overflow and carry ----------------
    load(8'h00, enc_i(4'h3, 3'd1, 8'hFF));
    load(8'h01, enc_i(4'h2, 3'd1, 8'h7F));   // R1=7FFF
    load(8'h02, enc_i(4'h3, 3'd2, 8'h01));
    load(8'h03, enc_i(4'h2, 3'd2, 8'h00));   // R2=0001
    load(8'h04, enc_r(4'h0, 3'd3, 3'd1, 3'd2)); // ADD R3=R1+R2
    load(8'h05, enc_r(4'h8, 3'd0, 3'd3, 3'd0)); // OUT R3
    load(8'h06, 16'hF000);
    beats0 = beats;
    run_to_halt(cyc);
    check("s2a_cycles", cyc, 23);
    check("s2a_data", last_beat, 16'h8000);
    check("s2a_nzvc", {n_f, z_f, v_f, c_f}, 4'b1010);
    // R2 is retained across the restart from HALT
    load(8'h00, enc_i(4'h3, 3'd1, 8'hFF));
    load(8'h01, enc_i(4'h2, 3'd1, 8'hFF));   // R1=FFFF
    load(8'h02, enc_r(4'h0, 3'd3, 3'd1, 3'd2));
    load(8'h03, enc_r(4'h8, 3'd0, 3'd3, 3'd0));
    load(8'h04, 16'hF000);
    beats0 = beats;
    run_to_halt(cyc);
    check("s2b_beats", beats - beats0, 1);
    check("s2b_data", last_beat, 16'h0000);
    check("s2b_nzvc", {n_f, z_f, v_f, c_f}, 4'b0101);

    // ---------------- 3: SUB and BZ ----------------
    load(8'h00, enc_r(4'h1, 3'd1, 3'd1, 3'd1)); // SUB R1=R1-R1
    load(8'h01, enc_i(4'h7, 3'd0, 8'h20));      // BZ 0x20
    load(8'h02, 16'hF000);
    load(8'h20, 16'hF000);
    run_to_halt(cyc);
    check("s3a_pc_taken", pc, 8'h21);
    check("s3a_nzvc", {n_f, z_f, v_f, c_f}, 4'b0101);
    load(8'h00, enc_i(4'h3, 3'd1, 8'h05));
    load(8'h01, enc_i(4'h2, 3'd1, 8'h00));      // R1=5
    load(8'h02, enc_i(4'h3, 3'd2, 8'h03));
    load(8'h03, enc_i(4'h2, 3'd2, 8'h00));      // R2=3
    load(8'h04, enc_r(4'h1, 3'd3, 3'd1, 3'd2)); // SUB R3=2
    load(8'h05, enc_i(4'h7, 3'd0, 8'h20));      // BZ not taken
    load(8'h06, enc_r(4'h8, 3'd0, 3'd3, 3'd0));
    load(8'h07, 16'hF000);
    beats0 = beats;
    run_to_halt(cyc);
    check("s3b_pc_seq", pc, 8'h08);
    check("s3b_data", last_beat, 16'h0002);
    check("s3b_beats", beats - beats0, 1);
    check("s3b_nzvc", {n_f, z_f, v_f, c_f}, 4'b0001);
    // 8000 - 0001 = 7FFF: signed overflow, no borrow
    load(8'h00, enc_i(4'h3, 3'd1, 8'h00));
    load(8'h01, enc_i(4'h2, 3'd1, 8'h80));
    load(8'h02, enc_i(4'h3, 3'd2, 8'h01));
    load(8'h03, enc_i(4'h2, 3'd2, 8'h00));
    load(8'h04, enc_r(4'h1, 3'd3, 3'd1, 3'd2));
    load(8'h05, 16'hF000);
    run_to_halt(cyc);
    check("s3c_nzvc", {n_f, z_f, v_f, c_f}, 4'b0011);
    check("s3c_pc", pc, 8'h06);

    // ---------------- 4: ST / LD round trip and timing ----------------
    load(8'h00, enc_i(4'h3, 3'd1, 8'hCD));
    load(8'h01, enc_i(4'h2, 3'd1, 8'hAB));   // R1=ABCD
    load(8'h02, enc_i(4'h5, 3'd1, 8'h40));   // ST R1 -> M[40]
    load(8'h03, enc_i(4'h4, 3'd2, 8'h40));   // LD R2 <- M[40]
    load(8'h04, enc_r(4'h8, 3'd0, 3'd2, 3'd0));
    load(8'h05, 16'hF000);
    beats0 = beats;
    run_to_halt(cyc);
    check("s4_cycles", cyc, 21);
    check("s4_data", last_beat, 16'hABCD);
    check("s4_pc", pc, 8'h06);

    // ---------------- 5: OUT back-pressure ----------------
    load(8'h00, enc_i(4'h3, 3'd1, 8'h5A));
    load(8'h01, enc_i(4'h2, 3'd1, 8'hC3));
    load(8'h02, enc_r(4'h8, 3'd0, 3'd1, 3'd0));
    load(8'h03, 16'hF000);
    out_ready = 1'b0;
    beats0 = beats;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      check("s5_hold_valid", out_valid, 1'b1);
      check("s5_hold_data", out_data, 16'hC35A);
      check("s5_hold_pc", pc, 8'h03);
    end
    check("s5_hold_busy", busy, 1'b1);
    out_ready = 1'b1;
    cyc = 0;
    wait_halt(cyc);
    check("s5_halted", halted, 1'b1);
    check("s5_beats", beats - beats0, 1);
    check("s5_data", last_beat, 16'hC35A);

    // ---------------- 6: reset while waiting in OUTW ----------------
    load_prog1();
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s6_valid", out_valid, 1'b0);
    check("s6_data", out_data, 16'h0000);
    check("s6_busy", busy, 1'b0);
    check("s6_halted", halted, 1'b0);
    check("s6_pc", pc, 8'h00);
    check("s6_flags", {n_f, z_f, v_f, c_f}, 4'b0000);
    out_ready = 1'b1;
    beats0 = beats;
    run_to_halt(cyc);
    check("s6_cycles", cyc, 14);
    check("s6_beats", beats - beats0, 1);
    check("s6_rerun_data", last_beat, 16'h1234);
    // R3 held 7FFF before the reset
    load(8'h00, enc_r(4'h8, 3'd0, 3'd3, 3'd0));
    load(8'h01, 16'hF000);
    beats0 = beats;
    run_to_halt(cyc);
    check("s6_r3_cleared", last_beat, 16'h0000);
    check("s6_r3_beats", beats - beats0, 1);

    // ---------------- start and load in the same IDLE cycle ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'hF000;
    start = 1'b1;
    step();
    load_en = 1'b0;
    start = 1'b0;
    cyc = 1;
    wait_halt(cyc);
    check("sl_cycles", cyc, 4);
    check("sl_pc", pc, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
